// File: rtl/jpeg_sched_pkg.sv
// Shared types and helpers for the JPEG MCU block scheduler.
// Colour modes, scheduler states and per-mode block counts.
package jpeg_sched_pkg;

  typedef enum logic [1:0] {
    MODE_GRAY,
    MODE_444,
    MODE_422,
    MODE_420
  } mode_e;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FINISH
  } sched_state_e;

  localparam int COEFS_PER_BLK = 64;

  function automatic logic [2:0] blocks_per_mcu(input mode_e m);
    logic [2:0] b;
    unique case (m)
      MODE_GRAY: b = 3'd1;
      MODE_444:  b = 3'd3;
      MODE_422:  b = 3'd4;
      default:   b = 3'd6;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/jpeg_blk_comp_map.sv
// Maps a block index within an MCU to its colour component.
// Also flags the final block of the MCU for the current mode.
module jpeg_blk_comp_map
  import jpeg_sched_pkg::*;
(
  input  mode_e      mode,
  input  logic [2:0] blk_idx,
  output logic [1:0] comp,
  output logic       is_last_blk
);

  always_comb begin
    comp = 2'd0;
    unique case (mode)
      MODE_GRAY: comp = 2'd0;
      MODE_444:  comp = blk_idx[1:0];
      MODE_422: begin
        case (blk_idx)
          3'd2:    comp = 2'd1;
          3'd3:    comp = 2'd2;
          default: comp = 2'd0;
        endcase
      end
      default: begin
        case (blk_idx)
          3'd4:    comp = 2'd1;
          3'd5:    comp = 2'd2;
          default: comp = 2'd0;
        endcase
      end
    endcase
  end

  assign is_last_blk = (blk_idx == blocks_per_mcu(mode) - 3'd1);

endmodule

// File: rtl/jpeg_mcu_block_scheduler.sv
// Streams one frame of coefficients into the IDCT, tagging each with
// its colour component and block/MCU boundary flags.
module jpeg_mcu_block_scheduler
  import jpeg_sched_pkg::*;
#(
  parameter int COEF_W = 12,
  parameter int MCU_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        cfg_mode,
  input  logic [MCU_W-1:0]  cfg_mcu_count,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [COEF_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [COEF_W-1:0] out_data,
  output logic [1:0]        out_comp,
  output logic              out_blk_first,
  output logic              out_blk_last,
  output logic              out_mcu_last
);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_STREAM = STREAM;
  localparam logic [1:0] S_FINISH = FINISH;
  localparam logic [5:0] LAST_COEF = 6'(COEFS_PER_BLK - 1);
  localparam logic [MCU_W-1:0] ONE = MCU_W'(1);

  logic [1:0]       state;
  mode_e            mode_q;
  logic [MCU_W-1:0] mcu_total;
  logic [MCU_W-1:0] mcu_cnt;
  logic [5:0]       coef_cnt;
  logic [2:0]       blk_idx;
  logic             busy_q;
  logic [1:0]       comp;
  logic             last_blk;
  logic             streaming;
  logic             xfer;
  logic             coef_end;

  jpeg_blk_comp_map u_map (
    .mode        (mode_q),
    .blk_idx     (blk_idx),
    .comp        (comp),
    .is_last_blk (last_blk)
  );

  assign streaming = (state == S_STREAM);
  assign out_valid = in_valid & streaming;
  assign in_ready  = out_ready & streaming;
  assign out_data  = in_data;
  assign xfer      = out_valid & out_ready;
  assign coef_end  = (coef_cnt == LAST_COEF);

  // Flags are only meaningful while a coefficient can be presented.
  assign out_comp      = streaming ? comp : 2'd0;
  assign out_blk_first = streaming & (coef_cnt == 6'd0);
  assign out_blk_last  = streaming & coef_end;
  assign out_mcu_last  = streaming & coef_end & last_blk;

  assign busy = busy_q;
  assign done = (state == S_FINISH);

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state     <= S_IDLE;
      coef_cnt  <= 6'd0;
      blk_idx   <= 3'd0;
      mcu_cnt   <= '0;
      busy_q    <= 1'b0;
      if (rst) begin
        mode_q    <= MODE_GRAY;
        mcu_total <= '0;
      end
    end else begin
      unique case (state)
        S_IDLE: begin
          coef_cnt <= 6'd0;
          blk_idx  <= 3'd0;
          mcu_cnt  <= '0;
          if (start) begin
            mode_q    <= mode_e'(cfg_mode);
            mcu_total <= cfg_mcu_count;
            busy_q    <= (cfg_mcu_count != '0);
            state     <= (cfg_mcu_count != '0) ? S_STREAM : S_FINISH;
          end
        end
        S_STREAM: begin
          if (xfer) begin
            coef_cnt <= coef_cnt + 6'd1;
            if (coef_end) begin
              if (last_blk) begin
                blk_idx <= 3'd0;
                if (mcu_cnt == mcu_total - ONE) begin
                  state <= S_FINISH;
                end else begin
                  mcu_cnt <= mcu_cnt + ONE;
                end
              end else begin
                blk_idx <= blk_idx + 3'd1;
              end
            end
          end
        end
        S_FINISH: begin
          state    <= S_IDLE;
          busy_q   <= 1'b0;
          coef_cnt <= 6'd0;
          blk_idx  <= 3'd0;
          mcu_cnt  <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jpeg_mcu_block_scheduler.sv
// Scoreboard bench for the MCU block scheduler: random data and
// handshake stalls checked against a per-transfer reference model.
module tb_jpeg_mcu_block_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_mcu_count;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;
  logic [1:0]  out_comp;
  logic        out_blk_first;
  logic        out_blk_last;
  logic        out_mcu_last;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  typedef struct packed {
    logic [11:0] data;
    logic [1:0]  comp;
    logic        first;
    logic        last;
    logic        mcu_last;
  } item_t;

  item_t exp_q[$];

  always #5 clk = ~clk;

  jpeg_mcu_block_scheduler #(.COEF_W(12), .MCU_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_mode      (cfg_mode),
    .cfg_mcu_count (cfg_mcu_count),
    .start         (start),
    .abort         (abort),
    .busy          (busy),
    .done          (done),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_comp      (out_comp),
    .out_blk_first (out_blk_first),
    .out_blk_last  (out_blk_last),
    .out_mcu_last  (out_mcu_last)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic int bpm_of(input int mode);
    case (mode)
      0: return 1;
      1: return 3;
      2: return 4;
      default: return 6;
    endcase
  endfunction

  // Luma blocks come first, then one Cb block, then one Cr block.
  function automatic int comp_of(input int mode, input int blk);
    int luma;
    luma = bpm_of(mode) - 2;
    if (mode == 0) return 0;
    if (blk < luma) return 0;
    return blk - luma + 1;
  endfunction

  // Every presented coefficient must match the head of the queue;
  // stalled cycles re-check the same entry, so flags must hold.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got data %0h with empty scoreboard", out_data);
      end else begin
        chk("xfer_item",
            32'({out_data, out_comp, out_blk_first, out_blk_last, out_mcu_last}),
            32'(exp_q[0]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
    if (done) done_cnt++;
  end

  task automatic run_frame(input int mode, input int cnt, input int rdy_pct,
                           input int val_pct, input int stop_at,
                           input bit use_rst, input int restart_at);
    int n, k, cyc, d0;
    bit x;
    logic [11:0] dq[$];
    item_t it;
    n = cnt * bpm_of(mode) * 64;
    for (int i = 0; i < n; i++) begin
      dq.push_back(12'($urandom));
      if (stop_at < 0 || i < stop_at) begin
        it.data     = dq[i];
        it.comp     = 2'(comp_of(mode, (i / 64) % bpm_of(mode)));
        it.first    = (i % 64 == 0);
        it.last     = (i % 64 == 63);
        it.mcu_last = (i % (64 * bpm_of(mode)) == 64 * bpm_of(mode) - 1);
        exp_q.push_back(it);
      end
    end
    d0 = done_cnt;
    @(posedge clk); #1;
    cfg_mode = 2'(mode);
    cfg_mcu_count = 16'(cnt);
    start = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_mode = 2'($urandom);
    k = 0;
    cyc = 0;
    while (k < n && cyc < 20000) begin
      if (stop_at >= 0 && k == stop_at) break;
      in_valid = ($urandom_range(99) < val_pct);
      out_ready = ($urandom_range(99) < rdy_pct);
      in_data = dq[k];
      if (restart_at >= 0 && k == restart_at) begin
        start = 1'b1;
        cfg_mode = 2'((mode + 1) % 4);
        cfg_mcu_count = 16'(cnt + 5);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (cyc == 0) chk("busy_stream", 32'(busy), 32'd1);
      x = out_valid & out_ready;
      @(posedge clk); #1;
      if (x) k++;
      cyc++;
    end
    start = 1'b0;
    if (cyc >= 20000) chk("frame_timeout", 32'(k), 32'(n));
    if (stop_at >= 0) begin
      in_valid = 1'b0;
      if (use_rst) rst = 1'b1;
      else abort = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      abort = 1'b0;
      in_valid = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("stop_busy", 32'(busy), 32'd0);
      chk("stop_idle", 32'({in_ready, out_valid, done, out_blk_first,
                            out_blk_last, out_mcu_last}), 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("stop_no_done", 32'(done_cnt - d0), 32'd0);
    end else begin
      in_valid = 1'b0;
      @(negedge clk);
      chk("done_pulse", 32'(done), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("done_low_busy", 32'({done, busy}), 32'd0);
      chk("done_count", 32'(done_cnt - d0), 32'd1);
    end
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic run_zero();
    int d0;
    d0 = done_cnt;
    @(posedge clk); #1;
    cfg_mode = 2'd3;
    cfg_mcu_count = 16'd0;
    start = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("zero_no_data", 32'({out_valid, busy}), 32'd0);
      if (i == 0) chk("zero_done_now", 32'(done), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("zero_done_count", 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    cfg_mode = 2'd0;
    cfg_mcu_count = 16'd0;
    start = 1'b0;
    abort = 1'b0;
    in_valid = 1'b1;
    in_data = 12'h5a5;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 32'({busy, done, in_ready, out_valid, out_blk_first,
                              out_blk_last, out_mcu_last}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    run_frame(3, 1, 100, 100, -1, 1'b0, -1);
    run_frame(0, 3, 60, 100, -1, 1'b0, -1);
    run_zero();
    run_frame(2, 2, 80, 90, 100, 1'b0, -1);
    run_frame(2, 1, 80, 90, -1, 1'b0, -1);
    run_frame(1, 2, 90, 90, -1, 1'b0, 50);
    run_frame(1, 2, 90, 90, 70, 1'b1, -1);
    run_frame(1, 1, 90, 90, -1, 1'b0, -1);
    for (int r = 0; r < 4; r++) begin
      run_frame(int'($urandom_range(3)), int'($urandom_range(2, 1)),
                70, 80, -1, 1'b0, -1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
